// File: rtl/link_pkg.sv
// Shared types and constants for the bit-level OFDM link loopback.
package link_pkg;

    // Transmitter sequencing: preamble, idle gap, scrambled payload.
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_PRE,
        TX_GAP,
        TX_DATA
    } tx_state_t;

    // Receiver sequencing mirrors the transmitter, offset by the channel delay.
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_CHECK,
        RX_WAIT,
        RX_DATA
    } rx_state_t;

    // Scrambler x^7 + x^4 + 1: feedback taps on state bits 6 and 3.
    localparam int SCR_W      = 7;
    localparam int SCR_TAP_HI = 6;
    localparam int SCR_TAP_LO = 3;

    localparam logic [15:0]      PREAMBLE_DEF = 16'hA5F0;
    localparam logic [SCR_W-1:0] SCR_SEED_DEF = 7'b1011101;

endpackage

// File: rtl/ofdm_scrambler.sv
// Additive 7-bit scrambler; the same block scrambles on TX and descrambles on RX.
module ofdm_scrambler
    import link_pkg::*;
#(
    parameter logic [SCR_W-1:0] SEED = SCR_SEED_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic step,
    output logic s_o
);

    logic [SCR_W-1:0] state_q;
    logic [SCR_W-1:0] state_d;

    assign s_o = state_q[SCR_TAP_HI] ^ state_q[SCR_TAP_LO];

    // Reload the seed at frame start, otherwise advance once per payload bit.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = SEED;
        end else if (step) begin
            state_d = {state_q[SCR_W-2:0], s_o};
        end
    end

    // Scrambler state register; reset returns it to the seed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/ofdm_link_loopback.sv
// Transmitter, fixed-delay air channel and receiver of a simplified 802.11a-style bit link.
module ofdm_link_loopback
    import link_pkg::*;
#(
    parameter int                   DATA_START    = 137,
    parameter int                   DATA_BITS     = 4,
    parameter int                   PRE_LEN       = 16,
    parameter logic [PRE_LEN-1:0]   PREAMBLE      = PREAMBLE_DEF,
    parameter logic [SCR_W-1:0]     SCR_SEED      = SCR_SEED_DEF,
    parameter int                   CHANNEL_DELAY = 351
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Start,
    input  logic Input,
    output logic Antenna,
    output logic Output,
    output logic Error
);

    // Both FSMs count edges since their own frame start; the receiver count
    // runs CHANNEL_DELAY+1 edges behind the transmitter count.
    localparam int            CW        = 16;
    localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_LEN);
    localparam logic [CW-1:0] GAP_LAST  = CW'(DATA_START - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_START + DATA_BITS - 1);
    localparam logic [CW-1:0] RX_TRIG   = CW'(CHANNEL_DELAY + 1);

    tx_state_t              tx_state_q, tx_state_d;
    logic [CW-1:0]          tx_cnt_q, tx_cnt_d;
    logic [PRE_LEN-1:0]     tx_pre_q, tx_pre_d;
    logic                   antenna_q, antenna_d;
    logic [CHANNEL_DELAY-1:0] chan_q, chan_d;
    logic                   dly_act_q, dly_act_d;
    logic [CW-1:0]          dly_cnt_q, dly_cnt_d;
    rx_state_t              rx_state_q, rx_state_d;
    logic [CW-1:0]          rx_cnt_q, rx_cnt_d;
    logic [PRE_LEN-1:0]     rx_pre_q, rx_pre_d;
    logic                   output_q, output_d;
    logic                   error_q, error_d;

    logic start_acc;
    logic tx_load, tx_step, tx_s;
    logic rx_load, rx_step, rx_s;
    logic rx_trig;
    logic chan_in;
    logic rx_bit;

    assign start_acc = (tx_state_q == TX_IDLE) && Start;
    assign chan_in   = antenna_q;
    assign rx_bit    = chan_q[CHANNEL_DELAY-1];

    ofdm_scrambler #(.SEED(SCR_SEED)) u_tx_scr (
        .clk  (Clock),
        .rst  (Reset),
        .load (tx_load),
        .step (tx_step),
        .s_o  (tx_s)
    );

    ofdm_scrambler #(.SEED(SCR_SEED)) u_rx_scr (
        .clk  (Clock),
        .rst  (Reset),
        .load (rx_load),
        .step (rx_step),
        .s_o  (rx_s)
    );

    // TX sequencing: preamble MSB first, zero gap, then Input XOR scrambler.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CW'(1);
        tx_pre_d   = tx_pre_q;
        antenna_d  = 1'b0;
        tx_load    = 1'b0;
        tx_step    = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = tx_cnt_q;
                if (Start) begin
                    tx_state_d = TX_PRE;
                    tx_cnt_d   = CW'(1);
                    tx_pre_d   = PREAMBLE;
                    tx_load    = 1'b1;
                end
            end
            TX_PRE: begin
                antenna_d = tx_pre_q[PRE_LEN-1];
                tx_pre_d  = {tx_pre_q[PRE_LEN-2:0], 1'b0};
                if (tx_cnt_q == PRE_LAST) tx_state_d = TX_GAP;
            end
            TX_GAP: begin
                if (tx_cnt_q == GAP_LAST) tx_state_d = TX_DATA;
            end
            TX_DATA: begin
                antenna_d = Input ^ tx_s;
                tx_step   = 1'b1;
                if (tx_cnt_q == DATA_LAST) tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Start-delay counter: fires the receiver CHANNEL_DELAY+1 edges after an
    // accepted Start. A Start accepted before the previous frame's receive
    // window opened retimes the receiver to the newer frame.
    always_comb begin
        dly_act_d = dly_act_q;
        dly_cnt_d = dly_cnt_q;
        rx_trig   = 1'b0;
        if (dly_act_q) begin
            if (dly_cnt_q == RX_TRIG) begin
                rx_trig   = 1'b1;
                dly_act_d = 1'b0;
            end else begin
                dly_cnt_d = dly_cnt_q + CW'(1);
            end
        end
        if (start_acc) begin
            dly_act_d = 1'b1;
            dly_cnt_d = CW'(1);
        end
    end

    // RX sequencing: preamble check, wait, then descramble the payload.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CW'(1);
        rx_pre_d   = rx_pre_q;
        output_d   = 1'b0;
        error_d    = error_q;
        rx_load    = 1'b0;
        rx_step    = 1'b0;
        chan_d     = {chan_q[CHANNEL_DELAY-2:0], chan_in};
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = rx_cnt_q;
                if (rx_trig) begin
                    rx_state_d = RX_CHECK;
                    rx_cnt_d   = CW'(1);
                    rx_pre_d   = PREAMBLE;
                    rx_load    = 1'b1;
                end
            end
            RX_CHECK: begin
                if (rx_bit != rx_pre_q[PRE_LEN-1]) error_d = 1'b1;
                rx_pre_d = {rx_pre_q[PRE_LEN-2:0], 1'b0};
                if (rx_cnt_q == PRE_LAST) rx_state_d = RX_WAIT;
            end
            RX_WAIT: begin
                if (rx_cnt_q == GAP_LAST) rx_state_d = RX_DATA;
            end
            RX_DATA: begin
                output_d = rx_bit ^ rx_s;
                rx_step  = 1'b1;
                if (rx_cnt_q == DATA_LAST) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
        // A newly accepted frame starts with a clean error flag.
        if (start_acc) error_d = 1'b0;
    end

    // State, channel and output registers; reset aborts any frame in flight.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            tx_state_q <= TX_IDLE;
            rx_state_q <= RX_IDLE;
            antenna_q  <= 1'b0;
            output_q   <= 1'b0;
            error_q    <= 1'b0;
            chan_q     <= '0;
            dly_act_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            rx_state_q <= rx_state_d;
            antenna_q  <= antenna_d;
            output_q   <= output_d;
            error_q    <= error_d;
            chan_q     <= chan_d;
            dly_act_q  <= dly_act_d;
        end
        tx_cnt_q  <= tx_cnt_d;
        tx_pre_q  <= tx_pre_d;
        dly_cnt_q <= dly_cnt_d;
        rx_cnt_q  <= rx_cnt_d;
        rx_pre_q  <= rx_pre_d;
    end

    assign Antenna = antenna_q;
    assign Output  = output_q;
    assign Error   = error_q;

endmodule

// File: tb/tb_ofdm_link_loopback.sv
// Directed bench for ofdm_link_loopback: frame timing, scrambling, preamble check, reset abort.
module tb_ofdm_link_loopback;

    localparam int NMAX = 500;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    logic Start = 1'b0;
    logic Input = 1'b0;
    logic Antenna;
    logic Output;
    logic Error;

    int compared   = 0;
    int mismatched = 0;

    // Expected constants: preamble A5F0 and scrambler outputs s0..s3 from
    // seed 1011101, worked by hand as 0,1,1,0 (bit k = s_k).
    logic [15:0] pre_pat = 16'hA5F0;
    logic [3:0]  scr_seq = 4'b0110;

    logic ant_log [0:NMAX];
    logic out_log [0:NMAX];
    logic err_log [0:NMAX];

    ofdm_link_loopback dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Start   (Start),
        .Input   (Input),
        .Antenna (Antenna),
        .Output  (Output),
        .Error   (Error)
    );

    always #5 Clock = ~Clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    function automatic logic exp_ant(input int n, input logic [3:0] din);
        logic e;
        e = 1'b0;
        if (n >= 1 && n <= 16) e = pre_pat[4'(16 - n)];
        else if (n >= 137 && n <= 140) e = din[2'(n - 137)] ^ scr_seq[2'(n - 137)];
        return e;
    endfunction

    function automatic logic exp_out(input int n, input logic [3:0] din);
        logic e;
        e = 1'b0;
        if (n >= 489 && n <= 492) e = din[2'(n - 489)];
        return e;
    endfunction

    // Launches one frame at E0 and logs the outputs after edges E0..E0+NMAX.
    // extra_start: edge offset of an extra Start pulse (-1 none); flip: corrupt
    // the first preamble bit entering the channel; rst_at: edge offset of a Reset.
    task automatic run_frame(input logic [3:0] din, input int extra_start,
                             input bit flip, input int rst_at);
        Start = 1'b1;
        Input = 1'b1;
        tick();
        Start = 1'b0;
        ant_log[0] = Antenna;
        out_log[0] = Output;
        err_log[0] = Error;
        for (int n = 1; n <= NMAX; n++) begin
            Input = (n >= 137 && n <= 140) ? din[2'(n - 137)] : 1'b1;
            Start = (n == extra_start);
            Reset = (n == rst_at);
            if (flip && n == 2) force dut.chan_in = 1'b0;
            tick();
            if (flip && n == 2) release dut.chan_in;
            Start = 1'b0;
            Reset = 1'b0;
            ant_log[n] = Antenna;
            out_log[n] = Output;
            err_log[n] = Error;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Start = 1'b0;
        Input = 1'b0;
        repeat (3) tick();
        compared++;
        if (Antenna !== 1'b0) begin mismatched++; $display("FAIL reset_antenna: got %b, required 0", Antenna); end
        compared++;
        if (Output !== 1'b0) begin mismatched++; $display("FAIL reset_output: got %b, required 0", Output); end
        compared++;
        if (Error !== 1'b0) begin mismatched++; $display("FAIL reset_error: got %b, required 0", Error); end
        Reset = 1'b0;
        Input = 1'b1;
        repeat (5) tick();
        compared++;
        if ({Antenna, Output, Error} !== 3'b000) begin
            mismatched++;
            $display("FAIL idle_outputs: got %b, required 000", {Antenna, Output, Error});
        end
    endtask

    task automatic test_basic_frame();
        logic [3:0] din = 4'b1001;
        run_frame(din, -1, 1'b0, -1);
        for (int n = 0; n <= NMAX; n++) begin
            compared++;
            if (ant_log[n] !== exp_ant(n, din)) begin
                mismatched++;
                $display("FAIL basic_antenna E0+%0d: got %b, required %b", n, ant_log[n], exp_ant(n, din));
            end
            compared++;
            if (out_log[n] !== exp_out(n, din)) begin
                mismatched++;
                $display("FAIL basic_output E0+%0d: got %b, required %b", n, out_log[n], exp_out(n, din));
            end
            compared++;
            if (err_log[n] !== 1'b0) begin
                mismatched++;
                $display("FAIL basic_error E0+%0d: got %b, required 0", n, err_log[n]);
            end
        end
    endtask

    task automatic test_all_ones();
        logic [3:0] din = 4'b1111;
        run_frame(din, -1, 1'b0, -1);
        for (int n = 130; n <= 145; n++) begin
            compared++;
            if (ant_log[n] !== exp_ant(n, din)) begin
                mismatched++;
                $display("FAIL ones_antenna E0+%0d: got %b, required %b", n, ant_log[n], exp_ant(n, din));
            end
        end
        for (int n = 485; n <= 496; n++) begin
            compared++;
            if (out_log[n] !== exp_out(n, din)) begin
                mismatched++;
                $display("FAIL ones_output E0+%0d: got %b, required %b", n, out_log[n], exp_out(n, din));
            end
        end
    endtask

    task automatic test_all_zeros();
        logic [3:0] din = 4'b0000;
        run_frame(din, -1, 1'b0, -1);
        for (int n = 130; n <= 145; n++) begin
            compared++;
            if (ant_log[n] !== exp_ant(n, din)) begin
                mismatched++;
                $display("FAIL zeros_antenna E0+%0d: got %b, required %b", n, ant_log[n], exp_ant(n, din));
            end
        end
        for (int n = 485; n <= 496; n++) begin
            compared++;
            if (out_log[n] !== exp_out(n, din)) begin
                mismatched++;
                $display("FAIL zeros_output E0+%0d: got %b, required %b", n, out_log[n], exp_out(n, din));
            end
        end
    endtask

    task automatic test_start_in_gap();
        logic [3:0] din = 4'b1001;
        run_frame(din, 60, 1'b0, -1);
        for (int n = 0; n <= NMAX; n++) begin
            compared++;
            if (ant_log[n] !== exp_ant(n, din)) begin
                mismatched++;
                $display("FAIL gapstart_antenna E0+%0d: got %b, required %b", n, ant_log[n], exp_ant(n, din));
            end
            compared++;
            if (out_log[n] !== exp_out(n, din)) begin
                mismatched++;
                $display("FAIL gapstart_output E0+%0d: got %b, required %b", n, out_log[n], exp_out(n, din));
            end
        end
    endtask

    task automatic test_preamble_error();
        logic [3:0] din = 4'b0110;
        logic       e;
        run_frame(din, -1, 1'b1, -1);
        for (int n = 0; n <= NMAX; n++) begin
            e = (n >= 353);
            compared++;
            if (err_log[n] !== e) begin
                mismatched++;
                $display("FAIL flip_error E0+%0d: got %b, required %b", n, err_log[n], e);
            end
        end
        for (int n = 485; n <= 496; n++) begin
            compared++;
            if (out_log[n] !== exp_out(n, din)) begin
                mismatched++;
                $display("FAIL flip_output E0+%0d: got %b, required %b", n, out_log[n], exp_out(n, din));
            end
        end
        repeat (10) tick();
        compared++;
        if (Error !== 1'b1) begin mismatched++; $display("FAIL error_sticky: got %b, required 1", Error); end
        run_frame(din, -1, 1'b0, -1);
        for (int n = 0; n <= NMAX; n++) begin
            compared++;
            if (err_log[n] !== 1'b0) begin
                mismatched++;
                $display("FAIL error_cleared E0+%0d: got %b, required 0", n, err_log[n]);
            end
        end
    endtask

    task automatic test_reset_mid_data();
        logic [3:0] din = 4'b1111;
        // Reset while the transmitter is sending payload bits.
        run_frame(din, -1, 1'b0, 139);
        compared++;
        if (ant_log[138] !== exp_ant(138, din)) begin
            mismatched++;
            $display("FAIL txrst_before E0+138: got %b, required %b", ant_log[138], exp_ant(138, din));
        end
        for (int n = 139; n <= NMAX; n++) begin
            compared++;
            if ({ant_log[n], out_log[n], err_log[n]} !== 3'b000) begin
                mismatched++;
                $display("FAIL txrst_quiet E0+%0d: got %b, required 000", n, {ant_log[n], out_log[n], err_log[n]});
            end
        end
        // Reset while the receiver is presenting payload, with Error raised.
        run_frame(din, -1, 1'b1, 490);
        compared++;
        if ({out_log[489], err_log[489]} !== 2'b11) begin
            mismatched++;
            $display("FAIL rxrst_before E0+489: got %b, required 11", {out_log[489], err_log[489]});
        end
        for (int n = 490; n <= NMAX; n++) begin
            compared++;
            if ({ant_log[n], out_log[n], err_log[n]} !== 3'b000) begin
                mismatched++;
                $display("FAIL rxrst_quiet E0+%0d: got %b, required 000", n, {ant_log[n], out_log[n], err_log[n]});
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_all_ones();
        test_all_zeros();
        test_start_in_gap();
        test_preamble_error();
        test_reset_mid_data();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
